lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random source with a valid/ready output stream, seed loading, multi-bit stepping and zero-state lock-up recovery. It replaces the fixed 32-bit single-step LFSR wherever scramblers, test-pattern generators or noise sources need a configurable width or polynomial, or must apply backpressure.

## Interface
- WIDTH, 32: state register width (≥ 2).
- TAPS, 32'hEA000001: WIDTH-bit tap mask; bit i set means state[i] feeds the XOR. TAPS[0] must be 1.
- SEED, 32'h974CA351: WIDTH-bit reset and recovery state; must be nonzero.
- STEP, 1: single-bit shifts applied per advance (1..WIDTH).
- OUT_W, 8: output word width (1..WIDTH).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  request to present words on the output stream.
- load  in  1  load seed_in this cycle.
- seed_in  in  WIDTH  seed value.
- out_ready  in  1  consumer accepts out_data.
- out_valid  out  1  out_data is valid.
- out_data  out  OUT_W  state[OUT_W-1:0].
- state  out  WIDTH  full current LFSR state.
- lockup  out  1  sticky flag: a zero state was replaced by SEED.
- adv_count  out  32  number of advances since reset or last load.

## Operation
- Single step: f(s) = { ^(s & TAPS), s[WIDTH-1:1] }, i.e. shift right with the feedback bit entering the MSB.
- An advance applies f STEP times within one cycle (unrolled combinationally).
- fire = out_valid & out_ready & ~load.
- Priority at each edge: rst > load > zero guard > fire > hold.
- rst: state=SEED, out_valid=0, lockup=0, adv_count=0.
- load:
  - seed_in≠0: state=seed_in, lockup=0.
  - seed_in=0: state=SEED, lockup=1.
  - Both cases: adv_count=0, out_valid=0.
- Zero guard: if state==0 with no load, state=SEED and lockup=1. This is unreachable for a valid TAPS; it acts as a safety net.
- fire: state = f^STEP(state); adv_count += 1, wrapping from 0xFFFFFFFF to 0.
- out_valid next value:
  - load: 0.
  - else if out_valid & ~out_ready: 1. A presented word is never withdrawn.
  - else: enable.
- While out_valid & ~out_ready, state and out_data hold stable.
- out_data and state are direct register views with no combinational path from inputs.

## Timing
- After rst deasserts: out_valid stays 0 until the first edge that samples enable=1. It is 1 from the following cycle.
- Fire at edge k: the new state and out_data are visible in cycle k+1. With continuous ready, there is one advance per cycle (throughput 1 word/clk).
- Load at edge k: the new state is visible in cycle k+1 with out_valid=0. out_valid can reassert at cycle k+2.
- A load concurrent with out_valid & out_ready: no fire, the word is dropped, and the load wins.
- enable dropping while out_valid=1 and out_ready=0: out_valid stays 1 until accepted, then falls on the next edge.
- rst mid-stream: all outputs return to reset values at that edge, regardless of load, enable or out_ready.
- lockup is only cleared by rst or by a nonzero load.

## Test plan
- Reset, then enable=1, out_ready=1 (defaults):
  - state=0x974CA351 after reset.
  - After the 1st fire: 0xCBA651A8, out_data=0xA8.
  - After the 2nd fire: 0x65D328D4, out_data=0xD4.
  - adv_count=2.
- STEP=2 (other defaults): a single fire from reset gives state=0x65D328D4 and adv_count=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with enable=1, then drop enable. out_valid stays 1 and state stays 0x974CA351 throughout.
  - Raise out_ready for one cycle: one advance to 0xCBA651A8, then out_valid=0.
- Load seed_in=0x00000001 while streaming: the next cycle has state=1, out_valid=0 and adv_count=0, then streaming resumes. A concurrent ready does not advance.
- Load seed_in=0: state=0x974CA351 and lockup=1. A subsequent load of 0x12345678 clears lockup.
- Period check, WIDTH=4, TAPS=4'h3, SEED=4'h1: the sequence returns to 0x1 after exactly 15 advances, and no state equals 0.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR pseudo-random word source.
// The state shifts right and the tap parity enters at the MSB. Each accepted
// word advances the state by STEP single-bit shifts in one cycle. The output
// is a valid/ready stream that never withdraws a presented word. A zero state
// is replaced by SEED, and this raises a sticky lockup flag.
module lfsr_gen #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = 32'hEA000001,
  parameter logic [WIDTH-1:0] SEED  = 32'h974CA351,
  parameter int               STEP  = 1,
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [WIDTH-1:0] state,
  output logic             lockup,
  output logic [31:0]      adv_count
);

  logic [WIDTH-1:0] state_reg, state_next;
  logic             out_valid_reg, out_valid_next;
  logic             lockup_reg, lockup_next;
  logic [31:0]      adv_count_reg, adv_count_next;
  logic             fire;

  // step_chain[k] is the current state after k single-bit shifts.
  logic [WIDTH-1:0] step_chain [0:STEP];

  assign step_chain[0] = state_reg;

  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_step
      assign step_chain[gi+1] = {^(step_chain[gi] & TAPS), step_chain[gi][WIDTH-1:1]};
    end
  endgenerate

  // A word is consumed only when it is presented and accepted.
  // A concurrent load drops the word.
  assign fire = out_valid_reg & out_ready & ~load;

  // Next-state selection: load beats the zero guard, which beats an advance.
  always_comb begin
    state_next     = state_reg;
    lockup_next    = lockup_reg;
    adv_count_next = adv_count_reg;
    out_valid_next = enable;

    if (load) begin
      adv_count_next = 32'd0;
      if (seed_in != '0) begin
        state_next  = seed_in;
        lockup_next = 1'b0;
      end else begin
        state_next  = SEED;
        lockup_next = 1'b1;
      end
    end else if (state_reg == '0) begin
      state_next  = SEED;
      lockup_next = 1'b1;
    end else if (fire) begin
      state_next     = step_chain[STEP];
      adv_count_next = adv_count_reg + 32'd1;
    end

    // A presented word stays valid until it is taken. A load cancels it.
    if (load) begin
      out_valid_next = 1'b0;
    end else if (out_valid_reg && !out_ready) begin
      out_valid_next = 1'b1;
    end
  end

  // State registers with synchronous reset to the SEED state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SEED;
      out_valid_reg <= 1'b0;
      lockup_reg    <= 1'b0;
      adv_count_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      lockup_reg    <= lockup_next;
      adv_count_reg <= adv_count_next;
    end
  end

  assign state     = state_reg;
  assign out_data  = state_reg[OUT_W-1:0];
  assign out_valid = out_valid_reg;
  assign lockup    = lockup_reg;
  assign adv_count = adv_count_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: self-checking bench for lfsr_gen.
// Three instances are used: the default configuration, a STEP=2 variant and
// a 4-bit maximal-length variant.
// The default instance is tracked every cycle by a transaction-level model.
module tb_lfsr_gen;

  localparam logic [31:0] SEED_A = 32'h974CA351;
  localparam logic [31:0] TAPS_A = 32'hEA000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] seed_a = 32'd0;
  logic [3:0]  seed_c = 4'd0;

  logic        a_out_valid, a_lockup;
  logic [7:0]  a_out_data;
  logic [31:0] a_state, a_adv_count;
  logic        b_out_valid, b_lockup;
  logic [7:0]  b_out_data;
  logic [31:0] b_state, b_adv_count;
  logic        c_out_valid, c_lockup;
  logic [3:0]  c_out_data;
  logic [3:0]  c_state;
  logic [31:0] c_adv_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model of the default instance.
  logic [31:0] m_state = SEED_A;
  logic        m_valid = 1'b0;
  logic        m_lock  = 1'b0;
  logic [31:0] m_cnt   = 32'd0;

  always #5 clk = ~clk;

  lfsr_gen dut_a (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .seed_in(seed_a),
    .out_ready(out_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .state(a_state), .lockup(a_lockup), .adv_count(a_adv_count)
  );

  lfsr_gen #(.STEP(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .seed_in(seed_a),
    .out_ready(out_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .state(b_state), .lockup(b_lockup), .adv_count(b_adv_count)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .STEP(1), .OUT_W(4)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .seed_in(seed_c),
    .out_ready(out_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .state(c_state), .lockup(c_lockup), .adv_count(c_adv_count)
  );

  // One LFSR step: parity of the tapped bits becomes the new MSB.
  function automatic logic [31:0] ref_step32(input logic [31:0] s);
    int fb;
    fb = $countones(s & TAPS_A) % 2;
    return (s >> 1) + (fb == 1 ? 32'h8000_0000 : 32'h0);
  endfunction

  function automatic logic [3:0] ref_step4(input logic [3:0] s);
    int fb;
    fb = $countones(s & 4'h3) % 2;
    return (s >> 1) + (fb == 1 ? 4'h8 : 4'h0);
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  // Samples are taken 1ns after the edge.
  task automatic tick();
    logic [31:0] ns, nc;
    logic        nv, nl;
    ns = m_state; nc = m_cnt; nl = m_lock; nv = m_valid;
    if (rst) begin
      ns = SEED_A; nv = 1'b0; nl = 1'b0; nc = 32'd0;
    end else begin
      if (load) nv = 1'b0;
      else if (m_valid && !out_ready) nv = 1'b1;
      else nv = enable;
      if (load) begin
        nc = 32'd0;
        if (seed_a != 32'd0) begin ns = seed_a; nl = 1'b0; end
        else begin ns = SEED_A; nl = 1'b1; end
      end else if (m_state == 32'd0) begin
        ns = SEED_A; nl = 1'b1;
      end else if (m_valid && out_ready) begin
        ns = ref_step32(m_state); nc = m_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    m_state = ns; m_valid = nv; m_lock = nl; m_cnt = nc;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; enable = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (a_state !== SEED_A || a_out_valid !== 1'b0 || a_lockup !== 1'b0 || a_adv_count !== 32'd0)
      $display("FAIL reset_a: state=%h valid=%b lockup=%b cnt=%0d, required %h 0 0 0",
               a_state, a_out_valid, a_lockup, a_adv_count, SEED_A);
    else pass_cnt++;
    total_cnt++;
    if (a_out_data !== 8'h51) $display("FAIL reset_data: got %h, required 51", a_out_data);
    else pass_cnt++;
    total_cnt++;
    if (b_state !== SEED_A || c_state !== 4'h1)
      $display("FAIL reset_bc: b=%h c=%h, required %h 1", b_state, c_state, SEED_A);
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_known_sequence();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    tick();
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_state !== SEED_A)
      $display("FAIL first_valid: valid=%b state=%h, required 1 %h", a_out_valid, a_state, SEED_A);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_state !== 32'hCBA651A8 || a_out_data !== 8'hA8)
      $display("FAIL fire1: state=%h data=%h, required CBA651A8 A8", a_state, a_out_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_state !== 32'h65D328D4 || a_out_data !== 8'hD4 || a_adv_count !== 32'd2)
      $display("FAIL fire2: state=%h data=%h cnt=%0d, required 65D328D4 D4 2",
               a_state, a_out_data, a_adv_count);
    else pass_cnt++;
    $display("test_known_sequence done");
  endtask

  task automatic test_step2();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (b_state !== 32'h65D328D4 || b_adv_count !== 32'd1)
      $display("FAIL step2: state=%h cnt=%0d, required 65D328D4 1", b_state, b_adv_count);
    else pass_cnt++;
    $display("test_step2 done");
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (a_out_valid !== 1'b1 || a_state !== SEED_A)
        $display("FAIL bp_hold%0d: valid=%b state=%h, required 1 %h", i, a_out_valid, a_state, SEED_A);
      else pass_cnt++;
    end
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (a_out_valid !== 1'b1 || a_state !== SEED_A)
        $display("FAIL bp_drop%0d: valid=%b state=%h, required 1 %h", i, a_out_valid, a_state, SEED_A);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (a_state !== 32'hCBA651A8 || a_out_valid !== 1'b0 || a_adv_count !== 32'd1)
      $display("FAIL bp_release: state=%h valid=%b cnt=%0d, required CBA651A8 0 1",
               a_state, a_out_valid, a_adv_count);
    else pass_cnt++;
    $display("test_backpressure done");
  endtask

  task automatic test_load();
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    load = 1'b1; seed_a = 32'h0000_0001;
    tick();
    load = 1'b0;
    total_cnt++;
    if (a_state !== 32'h1 || a_out_valid !== 1'b0 || a_adv_count !== 32'd0)
      $display("FAIL load: state=%h valid=%b cnt=%0d, required 00000001 0 0",
               a_state, a_out_valid, a_adv_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_state !== 32'h1)
      $display("FAIL load_resume: valid=%b state=%h, required 1 00000001", a_out_valid, a_state);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_state !== 32'h8000_0000 || a_adv_count !== 32'd1)
      $display("FAIL load_fire: state=%h cnt=%0d, required 80000000 1", a_state, a_adv_count);
    else pass_cnt++;
    $display("test_load done");
  endtask

  task automatic test_load_zero();
    load = 1'b1; seed_a = 32'd0;
    tick();
    load = 1'b0;
    total_cnt++;
    if (a_state !== SEED_A || a_lockup !== 1'b1 || a_out_valid !== 1'b0)
      $display("FAIL load_zero: state=%h lockup=%b valid=%b, required %h 1 0",
               a_state, a_lockup, a_out_valid, SEED_A);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (a_lockup !== 1'b1) $display("FAIL lockup_sticky: got %b, required 1", a_lockup);
    else pass_cnt++;
    load = 1'b1; seed_a = 32'h12345678;
    tick();
    load = 1'b0;
    total_cnt++;
    if (a_lockup !== 1'b0 || a_state !== 32'h12345678)
      $display("FAIL lockup_clear: lockup=%b state=%h, required 0 12345678", a_lockup, a_state);
    else pass_cnt++;
    $display("test_load_zero done");
  endtask

  task automatic test_period();
    logic [3:0] cs;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    tick();
    cs = 4'h1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      cs = ref_step4(cs);
      total_cnt++;
      if (c_state !== cs || c_state === 4'h0 || (i < 15 && c_state === 4'h1) || (i == 15 && c_state !== 4'h1))
        $display("FAIL period_%0d: state=%h, required %h (nonzero, returns to 1 only at 15)", i, c_state, cs);
      else pass_cnt++;
    end
    total_cnt++;
    if (c_adv_count !== 32'd15) $display("FAIL period_count: got %0d, required 15", c_adv_count);
    else pass_cnt++;
    $display("test_period done");
  endtask

  task automatic test_random();
    logic acc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom % 60) == 0;
      load      = ($urandom % 12) == 0;
      seed_a    = (($urandom % 4) == 0) ? 32'd0 : $urandom;
      enable    = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      acc       = m_valid & out_ready & ~load & ~rst;
      if (acc) $display("word %0d accepted: %h", i, m_state[7:0]);
      tick();
      total_cnt++;
      if (a_state !== m_state || a_out_valid !== m_valid || a_lockup !== m_lock ||
          a_adv_count !== m_cnt || a_out_data !== m_state[7:0])
        $display("FAIL random_%0d: state=%h valid=%b lockup=%b cnt=%0d, required %h %b %b %0d",
                 i, a_state, a_out_valid, a_lockup, a_adv_count, m_state, m_valid, m_lock, m_cnt);
      else pass_cnt++;
    end
    rst = 1'b0; load = 1'b0; enable = 1'b0; out_ready = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_known_sequence();
    test_step2();
    test_backpressure();
    test_load();
    test_load_zero();
    test_period();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
